// File: rtl/local_coincidence_pkg.sv
// Shared constants and types for the local coincidence trigger block.
// Sizes the channel count default and the width of the window/threshold configuration.
package local_coincidence_pkg;

    localparam int LC_N_CHANNELS_DEFAULT = 24;
    localparam int LC_CNT_W              = 16;

    typedef logic [LC_CNT_W-1:0] lc_cfg_t;

endpackage

// File: rtl/local_coincidence_window_stretcher.sv
// Per-channel rising-edge detector feeding a retriggerable down counter.
// The channel is "windowed" for exactly i_width cycles after its most recent edge.
module lc_window_stretcher
    import local_coincidence_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    i_trig,
    input  lc_cfg_t i_width,
    output logic    o_win
);

    logic    r_trig_q;
    lc_cfg_t r_cnt;
    logic    w_edge;

    assign w_edge = i_trig & ~r_trig_q;

    // An edge always reloads, so a retrigger extends the window; a width of zero loads
    // zero and therefore never opens one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trig_q <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_trig_q <= i_trig;
            if (w_edge) begin
                r_cnt <= i_width;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - LC_CNT_W'(1);
            end
        end
    end

    assign o_win = (r_cnt != '0);

endmodule

// File: rtl/local_coincidence.sv
// Local coincidence trigger: flags each windowed channel whenever at least
// n_lc_thr channels are windowed at the same time.
module local_coincidence
    import local_coincidence_pkg::*;
#(
    parameter int N_CHANNELS = LC_N_CHANNELS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LC_CNT_W-1:0]   lc_window_width,
    input  logic [LC_CNT_W-1:0]   n_lc_thr,
    input  logic [N_CHANNELS-1:0] trig,
    output logic [N_CHANNELS-1:0] local_coinc
);

    localparam int ACTIVE_W = $clog2(N_CHANNELS + 1);

    logic [N_CHANNELS-1:0] w_win;
    logic [ACTIVE_W-1:0]   w_n_active;
    logic                  w_coinc;
    logic [N_CHANNELS-1:0] r_local_coinc;

    for (genvar g = 0; g < N_CHANNELS; g++) begin : g_chan
        lc_window_stretcher u_stretcher (
            .clk     (clk),
            .rst     (rst),
            .i_trig  (trig[g]),
            .i_width (lc_window_width),
            .o_win   (w_win[g])
        );
    end

    always_comb begin
        w_n_active = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            w_n_active = w_n_active + ACTIVE_W'(w_win[i]);
        end
    end

    // Thresholds above the channel count can never be met since n_active is bounded.
    assign w_coinc = (LC_CNT_W'(w_n_active) >= n_lc_thr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_local_coinc <= '0;
        end else begin
            r_local_coinc <= w_coinc ? w_win : '0;
        end
    end

    assign local_coinc = r_local_coinc;

endmodule

// File: tb/tb_local_coincidence.sv
// Directed self-checking bench for local_coincidence with hand-derived expectations.
module tb_local_coincidence;

    logic        clk;
    logic        rst;
    logic [15:0] lc_window_width;
    logic [15:0] n_lc_thr;
    logic [23:0] trig;
    logic [23:0] local_coinc;

    int nAsserts = 0;
    int nFail    = 0;

    local_coincidence #(.N_CHANNELS(24)) dut (
        .clk             (clk),
        .rst             (rst),
        .lc_window_width (lc_window_width),
        .n_lc_thr        (n_lc_thr),
        .trig            (trig),
        .local_coinc     (local_coinc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge; inputs and checks both happen 1 time unit later.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Shift test: channel k is windowed after edge N+j when k <= j <= k+8.
    function automatic logic [23:0] shiftExpect(input int j);
        logic [23:0] m;
        int          c;
        m = '0;
        c = 0;
        for (int k = 0; k < 24; k++) begin
            if (k <= j && j <= k + 8) begin
                m[k] = 1'b1;
                c++;
            end
        end
        return (c >= 4) ? m : 24'h0;
    endfunction

    logic [23:0] wZeroPat [6];

    initial begin
        wZeroPat[0] = 24'hA5A5A5; wZeroPat[1] = 24'h000000; wZeroPat[2] = 24'hFFFFFF;
        wZeroPat[3] = 24'h000000; wZeroPat[4] = 24'h123456; wZeroPat[5] = 24'h000000;

        rst = 1'b1; trig = '0; lc_window_width = '0; n_lc_thr = '0;
        repeat (2) applyStimulus();
        checkOutput("reset", local_coinc, 24'h0);
        rst = 1'b0;

        $display("[TB] isolated pulse on channel 5");
        lc_window_width = 16'd9; n_lc_thr = 16'd2;
        trig[5] = 1'b1;
        applyStimulus();
        trig = '0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus();
            checkOutput("pulse_t2", local_coinc, 24'h0);
        end
        n_lc_thr = 16'd1;
        trig[5] = 1'b1;
        applyStimulus();
        checkOutput("pulse_t1_edge", local_coinc, 24'h0);
        trig = '0;
        for (int i = 1; i <= 9; i++) begin
            applyStimulus();
            checkOutput("pulse_t1_win", local_coinc, 24'h000020);
        end
        applyStimulus();
        checkOutput("pulse_t1_end", local_coinc, 24'h0);

        $display("[TB] simultaneous edges on channels 0..2");
        lc_window_width = 16'd4; n_lc_thr = 16'd3;
        trig = 24'h7;
        applyStimulus();
        checkOutput("simul_edge", local_coinc, 24'h0);
        trig = '0;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus();
            checkOutput("simul_t3", local_coinc, 24'h7);
        end
        applyStimulus();
        checkOutput("simul_end", local_coinc, 24'h0);
        applyStimulus();
        n_lc_thr = 16'd4;
        trig = 24'h7;
        applyStimulus();
        trig = '0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            checkOutput("simul_t4", local_coinc, 24'h0);
        end

        $display("[TB] retrigger with channel 1 held windowed");
        lc_window_width = 16'd40; n_lc_thr = 16'd2;
        trig = 24'h2;
        applyStimulus();
        lc_window_width = 16'd9;
        trig = 24'h1;
        applyStimulus();
        checkOutput("retrig_edge", local_coinc, 24'h0);
        for (int s = 1; s <= 14; s++) begin
            trig = (s == 5) ? 24'h1 : 24'h0;
            applyStimulus();
            checkOutput("retrig_win", local_coinc, 24'h3);
        end
        trig = '0;
        applyStimulus();
        checkOutput("retrig_end", local_coinc, 24'h0);
        repeat (30) applyStimulus();
        checkOutput("retrig_clear", local_coinc, 24'h0);

        $display("[TB] one-hot shift across all channels");
        lc_window_width = 16'd9; n_lc_thr = 16'd4;
        trig = 24'h1;
        applyStimulus();
        checkOutput("shift_edge", local_coinc, 24'h0);
        for (int s = 1; s <= 35; s++) begin
            trig = (s <= 23) ? (24'h1 << s) : 24'h800000;
            applyStimulus();
            checkOutput($sformatf("shift_%0d", s), local_coinc, shiftExpect(s - 1));
        end
        trig = '0;
        repeat (3) applyStimulus();

        $display("[TB] threshold boundaries with all channels");
        n_lc_thr = 16'd24;
        trig = 24'hFFFFFF;
        applyStimulus();
        trig = '0;
        applyStimulus();
        checkOutput("t24_a", local_coinc, 24'hFFFFFF);
        applyStimulus();
        checkOutput("t24_b", local_coinc, 24'hFFFFFF);
        n_lc_thr = 16'd25;
        applyStimulus();
        checkOutput("t25", local_coinc, 24'h0);
        n_lc_thr = 16'd0;
        applyStimulus();
        checkOutput("t0", local_coinc, 24'hFFFFFF);
        for (int i = 5; i <= 9; i++) begin
            applyStimulus();
            checkOutput("t0_win", local_coinc, 24'hFFFFFF);
        end
        applyStimulus();
        checkOutput("t0_end", local_coinc, 24'h0);

        $display("[TB] zero window width");
        lc_window_width = 16'd0; n_lc_thr = 16'd1;
        for (int i = 0; i < 6; i++) begin
            trig = wZeroPat[i];
            applyStimulus();
            checkOutput("w0", local_coinc, 24'h0);
        end

        $display("[TB] reset mid-window with held level");
        lc_window_width = 16'd9; n_lc_thr = 16'd1;
        trig = 24'h8;
        applyStimulus();
        checkOutput("rst_pre_edge", local_coinc, 24'h0);
        applyStimulus();
        checkOutput("rst_pre_win1", local_coinc, 24'h8);
        applyStimulus();
        checkOutput("rst_pre_win2", local_coinc, 24'h8);
        rst = 1'b1;
        applyStimulus();
        checkOutput("rst_mid", local_coinc, 24'h0);
        rst = 1'b0;
        applyStimulus();
        checkOutput("rst_release", local_coinc, 24'h0);
        for (int i = 1; i <= 9; i++) begin
            applyStimulus();
            checkOutput("rst_retrig", local_coinc, 24'h8);
        end
        applyStimulus();
        checkOutput("rst_retrig_end", local_coinc, 24'h0);
        applyStimulus();
        checkOutput("rst_held_once", local_coinc, 24'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
